tour_cmd_seq: RTL and testbench

Command source that drives cmd_proc during an autonomous knight's tour, i.e. the writer side of the cmd/cmd_rdy/clr_cmd_rdy/send_resp interface that cmd_proc reads. On tour_go it walks the solved move list and turns each knight move into two cmd_proc commands: a vertical leg, then a horizontal leg with fanfare. It waits for cmd_proc's send_resp after each leg before issuing the next. When idle it passes the UART_wrapper command path through to cmd_proc unchanged.

---
 rtl/knight_pkg.sv | 31 +++
 rtl/tour_move_dec.sv | 30 +++
 rtl/tour_cmd_seq.sv | 96 +++++++++
 tb/tb_tour_cmd_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// Shared encodings for the knight's-tour command sequencer: cmd_proc opcodes,
// headings, UART response bytes and the sequencer state type.
package knight_pkg;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_V,
    HOLD_V,
    PUSH_H,
    HOLD_H
  } tour_state_t;

  // Packs one cmd_proc command word: opcode, heading, square count.
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] squares);
    return {op, hdg, squares};
  endfunction

endpackage

// File: rtl/tour_move_dec.sv
// Turns a one-hot knight move into its vertical and horizontal cmd_proc legs.
// Lowest set bit wins; an all-zero move is flagged invalid.
module tour_move_dec
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vcmd,
  output logic [15:0] hcmd,
  output logic        invalid
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    vcmd    = '0;
    hcmd    = '0;
    invalid = 1'b0;
    casez (move)
      8'b???????1: begin vcmd = mk_cmd(OP_MOVE, HDG_N, 4'd2); hcmd = mk_cmd(OP_MOVE_FF, HDG_E, 4'd1); end
      8'b??????10: begin vcmd = mk_cmd(OP_MOVE, HDG_N, 4'd2); hcmd = mk_cmd(OP_MOVE_FF, HDG_W, 4'd1); end
      8'b?????100: begin vcmd = mk_cmd(OP_MOVE, HDG_N, 4'd1); hcmd = mk_cmd(OP_MOVE_FF, HDG_W, 4'd2); end
      8'b????1000: begin vcmd = mk_cmd(OP_MOVE, HDG_S, 4'd1); hcmd = mk_cmd(OP_MOVE_FF, HDG_W, 4'd2); end
      8'b???10000: begin vcmd = mk_cmd(OP_MOVE, HDG_S, 4'd2); hcmd = mk_cmd(OP_MOVE_FF, HDG_W, 4'd1); end
      8'b??100000: begin vcmd = mk_cmd(OP_MOVE, HDG_S, 4'd2); hcmd = mk_cmd(OP_MOVE_FF, HDG_E, 4'd1); end
      8'b?1000000: begin vcmd = mk_cmd(OP_MOVE, HDG_S, 4'd1); hcmd = mk_cmd(OP_MOVE_FF, HDG_E, 4'd2); end
      8'b10000000: begin vcmd = mk_cmd(OP_MOVE, HDG_N, 4'd1); hcmd = mk_cmd(OP_MOVE_FF, HDG_E, 4'd2); end
      default:     invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Writer side of the cmd_proc command interface: replays the solved tour as
// vertical/horizontal leg pairs, and passes UART commands through when idle.
module tour_cmd_seq
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tour_go,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  tour_state_t state;
  logic [15:0] vcmd;
  logic [15:0] hcmd;
  logic        invalid;
  logic        last_move;

  tour_move_dec u_dec (
    .move    (move),
    .vcmd    (vcmd),
    .hcmd    (hcmd),
    .invalid (invalid)
  );

  assign last_move = (mv_indx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      unique case (state)
        IDLE: if (tour_go) begin
          mv_indx <= '0;
          state   <= PUSH_V;
        end
        // move is only valid for the new index once we sit in PUSH_V
        PUSH_V: begin
          if (invalid)          state <= IDLE;
          else if (clr_cmd_rdy) state <= send_resp ? PUSH_H : HOLD_V;
        end
        HOLD_V: if (send_resp) state <= PUSH_H;
        PUSH_H: begin
          if (clr_cmd_rdy && send_resp) begin
            if (last_move) state <= IDLE;
            else begin
              mv_indx <= mv_indx + 1'b1;
              state   <= PUSH_V;
            end
          end else if (clr_cmd_rdy) begin
            state <= HOLD_H;
          end
        end
        HOLD_H: if (send_resp) begin
          if (last_move) state <= IDLE;
          else begin
            mv_indx <= mv_indx + 1'b1;
            state   <= PUSH_V;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = RESP_ACK;
    if (state != IDLE) begin
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_POS;
      cmd              = (state == PUSH_V || state == HOLD_V) ? vcmd : hcmd;
      cmd_rdy          = (state == PUSH_V && !invalid) || (state == PUSH_H);
      // End-of-tour is signalled while the final horizontal leg completes.
      if (state == HOLD_H && last_move) resp = RESP_ACK;
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: decode table, full tour against a stub
// cmd_proc with a command scoreboard, plus handshake, abort and reset corners.
module tb_tour_cmd_seq;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             tour_go;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy_UART;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [7:0]       resp;

  logic [7:0]  tour_mem [0:31];
  logic [15:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          legs  = 0;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;
  assign move = tour_mem[mv_indx];

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .tour_go          (tour_go),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_go();
    tour_go = 1'b1;
    @(negedge clk);
    tour_go = 1'b0;
  endtask

  // Stub cmd_proc: wait for a command, score it, consume it, then answer it.
  task automatic serve_leg(input string tag, input bit both, input logic [7:0] hold_resp);
    logic [15:0] exp_cmd;
    int n;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " cmd_rdy"}, 32'(cmd_rdy), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp_cmd = exp_q.pop_front();
      check({tag, " cmd"}, 32'(cmd), 32'(exp_cmd));
    end
    legs++;
    clr_cmd_rdy = 1'b1;
    send_resp   = both;
    #1;
    check({tag, " clr_uart"}, 32'(clr_cmd_rdy_UART), 32'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    if (!both) begin
      check({tag, " hold cmd_rdy"}, 32'(cmd_rdy), 32'd0);
      check({tag, " hold resp"}, 32'(resp), 32'(hold_resp));
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{8'h01, 16'h2002, 16'h3BF1};
    vecs[1] = '{8'h02, 16'h2002, 16'h33F1};
    vecs[2] = '{8'h04, 16'h2001, 16'h33F2};
    vecs[3] = '{8'h08, 16'h27F1, 16'h33F2};
    vecs[4] = '{8'h10, 16'h27F2, 16'h33F1};
    vecs[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    vecs[6] = '{8'h40, 16'h27F1, 16'h3BF2};
    vecs[7] = '{8'h80, 16'h2001, 16'h3BF2};
    vecs[8] = '{8'h0C, 16'h2001, 16'h33F2};
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h00;

    rst = 1'b1; tour_go = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    #12;
    check("reset mv_indx", 32'(mv_indx), 32'd0);
    check("reset cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("reset resp", 32'(resp), 32'hA5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Idle pass-through
    cmd_UART = 16'h2001; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    check("idle cmd", 32'(cmd), 32'h2001);
    check("idle cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("idle clr_uart", 32'(clr_cmd_rdy_UART), 32'd1);
    check("idle resp", 32'(resp), 32'hA5);
    @(negedge clk);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    #1;
    check("idle clr_uart low", 32'(clr_cmd_rdy_UART), 32'd0);
    @(negedge clk);

    // Decode table: one move per tour, next entry zero so the tour aborts
    for (int i = 0; i < 9; i++) begin
      tour_mem[0] = vecs[i].mv;
      tour_mem[1] = 8'h00;
      exp_q.push_back(vecs[i].v);
      exp_q.push_back(vecs[i].h);
      pulse_go();
      check($sformatf("v%0d go latency", i), 32'(cmd_rdy), 32'd1);
      serve_leg($sformatf("v%0d V", i), 1'b0, 8'h5A);
      serve_leg($sformatf("v%0d H", i), 1'b0, 8'h5A);
      check($sformatf("v%0d abort cmd_rdy", i), 32'(cmd_rdy), 32'd0);
      check($sformatf("v%0d abort mv_indx", i), 32'(mv_indx), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d idle resp", i), 32'(resp), 32'hA5);
    end

    // Simultaneous clr/send_resp in PUSH_V, with a UART command pending mid-tour
    tour_mem[0] = 8'h01; tour_mem[1] = 8'h00;
    exp_q.push_back(16'h2002);
    exp_q.push_back(16'h3BF1);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    pulse_go();
    serve_leg("sim V", 1'b1, 8'h5A);
    check("sim straight to PUSH_H", 32'(cmd_rdy), 32'd1);
    serve_leg("sim H", 1'b0, 8'h5A);
    check("sim abort ignores uart rdy", 32'(cmd_rdy), 32'd0);
    cmd_rdy_UART = 1'b0;
    @(negedge clk);

    // Full tour
    for (int i = 0; i < NUM_MOVES; i++) begin
      tour_mem[i] = vecs[i % 8].mv;
      exp_q.push_back(vecs[i % 8].v);
      exp_q.push_back(vecs[i % 8].h);
    end
    legs = 0;
    pulse_go();
    for (int i = 0; i < NUM_MOVES; i++) begin
      check($sformatf("tour mv_indx %0d", i), 32'(mv_indx), 32'(i));
      if (i == 3) begin
        pulse_go();
        check("tour_go ignored", 32'(mv_indx), 32'd3);
      end
      if (i == 4) begin
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("lone send_resp ignored", 32'(cmd_rdy), 32'd1);
      end
      serve_leg($sformatf("tour%0d V", i), 1'b0, 8'h5A);
      serve_leg($sformatf("tour%0d H", i), 1'b0, (i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
    end
    check("tour legs", 32'(legs), 32'd48);
    check("tour end cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("tour end resp", 32'(resp), 32'hA5);
    check("tour end mv_indx", 32'(mv_indx), 32'(NUM_MOVES - 1));

    // Asynchronous reset in HOLD_H of move 1
    exp_q.delete();
    exp_q.push_back(vecs[0].v);
    exp_q.push_back(vecs[0].h);
    exp_q.push_back(vecs[1].v);
    pulse_go();
    serve_leg("rst m0 V", 1'b0, 8'h5A);
    serve_leg("rst m0 H", 1'b0, 8'h5A);
    serve_leg("rst m1 V", 1'b0, 8'h5A);
    check("rst PUSH_H cmd", 32'(cmd), 32'(vecs[1].h));
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("rst HOLD_H resp", 32'(resp), 32'h5A);
    cmd_rdy_UART = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async rst cmd_rdy follows uart", 32'(cmd_rdy), 32'd1);
    check("async rst mv_indx", 32'(mv_indx), 32'd0);
    check("async rst resp", 32'(resp), 32'hA5);
    #1 rst = 1'b0;
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    #1;
    check("post rst cmd_rdy", 32'(cmd_rdy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
